// File: rtl/write_sel_encoder.sv
// -----------------------------------------------------------------------------
// write_sel_encoder
//
// Collects write requests from the datapath register sources (PC, DR, R1-R5).
// Unserviced requests are kept in a sticky pending set. One source is chosen
// each cycle, and its registered 3-bit select code goes to the write-enable
// decoder.
//
// Parameters
//   IDLE_CODE : code driven when no write is issued (decoder leaves it unmapped)
//   CNT_W     : width of the saturating issued-write counter
//
// Ports
//   clk       in   system clock, rising edge
//   rst_n     in   asynchronous active-low reset
//   req       in   [6:0] write request strobes (bit0=PC, bit1=DR, bit2..6=R1..R5)
//   hold      in   controller stall; no grant while high
//   clr_err   in   synchronous clear of collision (a new collision wins)
//   sel_code  out  [2:0] select code: 0=PC, 1=DR, 2..6=R1..R5, else IDLE_CODE
//   sel_valid out  sel_code carries a real write this cycle
//   grant     out  [6:0] one-hot acknowledge of the source being written
//   pending   out  [6:0] latched, not-yet-granted requests
//   collision out  sticky: a request hit a source that was already pending
//   wr_count  out  [CNT_W-1:0] writes issued, saturating at all-ones
//
// Configuration
//   WSE_ROUND_ROBIN_EN : when defined, selection is round-robin. The search
//                        starts after the last granted index and wraps from 6
//                        to 0. When undefined, the lowest index wins (fixed
//                        priority).
//
// All outputs are registered. No combinational path runs from inputs to
// outputs.
// -----------------------------------------------------------------------------
module write_sel_encoder #(
  parameter logic [2:0]  IDLE_CODE = 3'd7,
  parameter int unsigned CNT_W     = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [6:0]       req,
  input  logic             hold,
  input  logic             clr_err,
  output logic [2:0]       sel_code,
  output logic             sel_valid,
  output logic [6:0]       grant,
  output logic [6:0]       pending,
  output logic             collision,
  output logic [CNT_W-1:0] wr_count
);

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [2:0]       sel_code_q, sel_code_d;
  logic [6:0]       grant_q, grant_d;
  logic [6:0]       pending_q, pending_d;
  logic             collision_q, collision_d;
  logic [CNT_W-1:0] wr_count_q, wr_count_d;

  logic [6:0] cand;
  logic       issue;
  logic [2:0] sel_idx;
  logic [6:0] gnt_now;
  logic       coll_set;

  // The candidate set includes this cycle's requests. A fresh request can
  // therefore be granted on the edge that samples it, which gives one-cycle
  // latency.
  assign cand  = pending_q | req;
  assign issue = (cand != 7'd0) && !hold;

`ifdef WSE_ROUND_ROBIN_EN
  logic [2:0] rr_ptr_q, rr_ptr_d;

  // Search order: rr_ptr+1, rr_ptr+2, ... and wrap modulo 7. The first hit wins.
  always_comb begin
    logic [3:0] pos;
    logic       found;
    // NOTE: every variable written here gets a default before any branch.
    // Otherwise a path that leaves it unassigned would infer a latch.
    sel_idx = 3'd0;
    found   = 1'b0;
    pos     = 4'd0;
    for (int k = 1; k <= 7; k++) begin
      pos = {1'b0, rr_ptr_q} + 4'(k);
      if (pos >= 4'd7) pos = pos - 4'd7;
      if (!found && cand[pos[2:0]]) begin
        found   = 1'b1;
        sel_idx = pos[2:0];
      end
    end
  end

  assign rr_ptr_d = issue ? sel_idx : rr_ptr_q;

  // After reset the pointer is 6, so the first search begins at PC (index 0).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= 3'd6;
    else        rr_ptr_q <= rr_ptr_d;
  end
`else
  // Fixed priority. The loop walks downward, so the lowest set index writes
  // last and wins.
  always_comb begin
    sel_idx = 3'd0;
    for (int i = 6; i >= 0; i--) begin
      if (cand[i]) sel_idx = 3'(i);
    end
  end
`endif

  assign gnt_now  = issue ? (7'd1 << sel_idx) : 7'd0;
  // A duplicate request for a source that is already pending and not granted
  // is dropped and flagged.
  assign coll_set = |(req & pending_q & ~gnt_now);

  always_comb begin
    state_d    = issue ? ST_ISSUE : ST_IDLE;
    sel_code_d = issue ? sel_idx : IDLE_CODE;
    grant_d    = gnt_now;
    // Granted bit: the grant retires the pending request. A request that
    // arrives in the same cycle re-pends only if one was already pending.
    // Otherwise the grant consumes the new request. Non-granted bits accumulate.
    for (int j = 0; j < 7; j++) begin
      pending_d[j] = gnt_now[j] ? (pending_q[j] & req[j])
                                : (pending_q[j] | req[j]);
    end
    if (coll_set)     collision_d = 1'b1;
    else if (clr_err) collision_d = 1'b0;
    else              collision_d = collision_q;
    if (issue && (wr_count_q != {CNT_W{1'b1}}))
      wr_count_d = wr_count_q + CNT_W'(1);
    else
      wr_count_d = wr_count_q;
  end

  // NOTE: state is updated only with non-blocking assignments. Each flop then
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sel_code_q  <= IDLE_CODE;
      grant_q     <= 7'd0;
      pending_q   <= 7'd0;
      collision_q <= 1'b0;
      wr_count_q  <= '0;
    end else begin
      state_q     <= state_d;
      sel_code_q  <= sel_code_d;
      grant_q     <= grant_d;
      pending_q   <= pending_d;
      collision_q <= collision_d;
      wr_count_q  <= wr_count_d;
    end
  end

  assign sel_code  = sel_code_q;
  assign sel_valid = (state_q == ST_ISSUE);
  assign grant     = grant_q;
  assign pending   = pending_q;
  assign collision = collision_q;
  assign wr_count  = wr_count_q;

endmodule

// File: tb/tb_write_sel_encoder.sv
// -----------------------------------------------------------------------------
// tb_write_sel_encoder
//
// Drives a table of hand-computed {inputs, expected outputs} records into
// write_sel_encoder. A scoreboard queue holds each record's expectation until
// the clock edge that produces it. Hand-written sequences cover a reset in the
// middle of a burst and counter saturation under a continuous re-grant. Rows
// whose expected order depends on the selection policy follow
// WSE_ROUND_ROBIN_EN.
// -----------------------------------------------------------------------------
module tb_write_sel_encoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [6:0] req;
  logic       hold;
  logic       clr_err;
  logic [2:0] sel_code;
  logic       sel_valid;
  logic [6:0] grant;
  logic [6:0] pending;
  logic       collision;
  logic [7:0] wr_count;

  write_sel_encoder #(.IDLE_CODE(3'd7), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .hold      (hold),
    .clr_err   (clr_err),
    .sel_code  (sel_code),
    .sel_valid (sel_valid),
    .grant     (grant),
    .pending   (pending),
    .collision (collision),
    .wr_count  (wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [6:0] req;
    logic       hold;
    logic       clr;
    logic [2:0] code;
    logic       valid;
    logic [6:0] grant;
    logic [6:0] pend;
    logic       coll;
    logic [7:0] cnt;
  } vec_t;

  vec_t tbl[$];
  vec_t sb_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   step_no  = 0;

  function automatic vec_t mk(input logic [6:0] r, input logic h, input logic c,
                              input logic [2:0] code, input logic v,
                              input logic [6:0] g, input logic [6:0] p,
                              input logic coll, input logic [7:0] cnt);
    vec_t x;
    x.req = r; x.hold = h; x.clr = c; x.code = code; x.valid = v;
    x.grant = g; x.pend = p; x.coll = coll; x.cnt = cnt;
    return x;
  endfunction

  // Convenience for an idle-output expectation.
  function automatic vec_t idle(input logic [6:0] r, input logic h, input logic c,
                                input logic [6:0] p, input logic coll,
                                input logic [7:0] cnt);
    return mk(r, h, c, 3'd7, 1'b0, 7'h00, p, coll, cnt);
  endfunction

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic compare_out();
    vec_t e;
    if (sb_q.size() == 0) begin
      n_checks++;
      n_errors++;
      $display("FAIL step%0d scoreboard empty", step_no);
    end else begin
      e = sb_q.pop_front();
      check($sformatf("step%0d sel_code", step_no),  32'(sel_code),  32'(e.code));
      check($sformatf("step%0d sel_valid", step_no), 32'(sel_valid), 32'(e.valid));
      check($sformatf("step%0d grant", step_no),     32'(grant),     32'(e.grant));
      check($sformatf("step%0d pending", step_no),   32'(pending),   32'(e.pend));
      check($sformatf("step%0d collision", step_no), 32'(collision), 32'(e.coll));
      check($sformatf("step%0d wr_count", step_no),  32'(wr_count),  32'(e.cnt));
    end
  endtask

  // Called at posedge+1: drive inputs, queue the expectation, then compare
  // just after the next edge.
  task automatic step(input vec_t v);
    req     = v.req;
    hold    = v.hold;
    clr_err = v.clr;
    sb_q.push_back(v);
    @(posedge clk);
    #1;
    step_no++;
    compare_out();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " sel_code"},  32'(sel_code),  32'd7);
    check({tag, " sel_valid"}, 32'(sel_valid), 32'd0);
    check({tag, " grant"},     32'(grant),     32'd0);
    check({tag, " pending"},   32'(pending),   32'd0);
    check({tag, " collision"}, 32'(collision), 32'd0);
    check({tag, " wr_count"},  32'(wr_count),  32'd0);
  endtask

  initial begin
    rst_n = 1'b0; req = 7'h00; hold = 1'b0; clr_err = 1'b0;

    // ---- Main table: r, h, c, expected code/valid/grant/pending/coll/cnt ----
    // All seven requests at once, from reset: 0..6 in order under either policy.
    tbl.push_back(mk(7'h7F, 0, 0, 3'd0, 1, 7'h01, 7'h7E, 0, 8'd1));
    tbl.push_back(mk(7'h00, 0, 0, 3'd1, 1, 7'h02, 7'h7C, 0, 8'd2));
    tbl.push_back(mk(7'h00, 0, 0, 3'd2, 1, 7'h04, 7'h78, 0, 8'd3));
    tbl.push_back(mk(7'h00, 0, 0, 3'd3, 1, 7'h08, 7'h70, 0, 8'd4));
    tbl.push_back(mk(7'h00, 0, 0, 3'd4, 1, 7'h10, 7'h60, 0, 8'd5));
    tbl.push_back(mk(7'h00, 0, 0, 3'd5, 1, 7'h20, 7'h40, 0, 8'd6));
    tbl.push_back(mk(7'h00, 0, 0, 3'd6, 1, 7'h40, 7'h00, 0, 8'd7));
    tbl.push_back(idle(7'h00, 0, 0, 7'h00, 0, 8'd7));
    // Repeated PC+DR request: 0 then 1.
    tbl.push_back(mk(7'h03, 0, 0, 3'd0, 1, 7'h01, 7'h02, 0, 8'd8));
    tbl.push_back(mk(7'h00, 0, 0, 3'd1, 1, 7'h02, 7'h00, 0, 8'd9));
    tbl.push_back(idle(7'h00, 0, 0, 7'h00, 0, 8'd9));
    // Single request for R1: consumed by its own grant, one-cycle latency.
    tbl.push_back(mk(7'h04, 0, 0, 3'd2, 1, 7'h04, 7'h00, 0, 8'd10));
    tbl.push_back(idle(7'h00, 0, 0, 7'h00, 0, 8'd10));
    // Hold: requests accumulate, nothing issued.
    tbl.push_back(idle(7'h41, 1, 0, 7'h41, 0, 8'd10));
    tbl.push_back(idle(7'h00, 1, 0, 7'h41, 0, 8'd10));
    tbl.push_back(idle(7'h00, 1, 0, 7'h41, 0, 8'd10));
`ifdef WSE_ROUND_ROBIN_EN
    // Pointer is 2 (last grant R1), so the search reaches 6 before 0.
    tbl.push_back(mk(7'h00, 0, 0, 3'd6, 1, 7'h40, 7'h01, 0, 8'd11));
    tbl.push_back(mk(7'h00, 0, 0, 3'd0, 1, 7'h01, 7'h00, 0, 8'd12));
`else
    tbl.push_back(mk(7'h00, 0, 0, 3'd0, 1, 7'h01, 7'h40, 0, 8'd11));
    tbl.push_back(mk(7'h00, 0, 0, 3'd6, 1, 7'h40, 7'h00, 0, 8'd12));
`endif
    tbl.push_back(idle(7'h00, 0, 0, 7'h00, 0, 8'd12));
    // Collision: duplicate R2 request while held, only one grant afterwards.
    tbl.push_back(idle(7'h08, 1, 0, 7'h08, 0, 8'd12));
    tbl.push_back(idle(7'h00, 1, 0, 7'h08, 0, 8'd12));
    tbl.push_back(idle(7'h08, 1, 0, 7'h08, 1, 8'd12));
    tbl.push_back(mk(7'h00, 0, 0, 3'd3, 1, 7'h08, 7'h00, 1, 8'd13));
    tbl.push_back(idle(7'h00, 0, 0, 7'h00, 1, 8'd13));
    tbl.push_back(idle(7'h00, 0, 1, 7'h00, 0, 8'd13));
    // Collision set beats clr_err in the same cycle.
    tbl.push_back(idle(7'h08, 1, 0, 7'h08, 0, 8'd13));
    tbl.push_back(idle(7'h08, 1, 1, 7'h08, 1, 8'd13));
    tbl.push_back(mk(7'h00, 0, 1, 3'd3, 1, 7'h08, 7'h00, 0, 8'd14));
    tbl.push_back(idle(7'h00, 0, 0, 7'h00, 0, 8'd14));
    // PC and R3 together after a grant of R2: the policies diverge.
`ifdef WSE_ROUND_ROBIN_EN
    tbl.push_back(mk(7'h11, 0, 0, 3'd4, 1, 7'h10, 7'h01, 0, 8'd15));
    tbl.push_back(mk(7'h00, 0, 0, 3'd0, 1, 7'h01, 7'h00, 0, 8'd16));
`else
    tbl.push_back(mk(7'h11, 0, 0, 3'd0, 1, 7'h01, 7'h10, 0, 8'd15));
    tbl.push_back(mk(7'h00, 0, 0, 3'd4, 1, 7'h10, 7'h00, 0, 8'd16));
`endif
    tbl.push_back(idle(7'h00, 0, 0, 7'h00, 0, 8'd16));

    // ---- Reset and first check ----
    repeat (2) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) step(tbl[i]);

    // ---- Reset in the middle of a burst ----
`ifdef WSE_ROUND_ROBIN_EN
    step(mk(7'h7F, 0, 0, 3'd1, 1, 7'h02, 7'h7D, 0, 8'd17));
`else
    step(mk(7'h7F, 0, 0, 3'd0, 1, 7'h01, 7'h7E, 0, 8'd17));
`endif
    req = 7'h00;
    #2 rst_n = 1'b0;
    #1 check_reset_values("midreset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < 3; i++) step(idle(7'h00, 0, 0, 7'h00, 0, 8'd0));

    // ---- Continuous re-grant of DR with pending set; counter saturates ----
    step(idle(7'h02, 1, 0, 7'h02, 0, 8'd0));
    for (int n = 1; n <= 260; n++)
      step(mk(7'h02, 0, 0, 3'd1, 1, 7'h02, 7'h02, 0, (n > 255) ? 8'd255 : 8'(n)));
    step(mk(7'h00, 0, 0, 3'd1, 1, 7'h02, 7'h00, 0, 8'd255));
    step(idle(7'h00, 0, 0, 7'h00, 0, 8'd255));

    check("scoreboard drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/write_sel_encoder.md
# write_sel_encoder

Collects write requests from the datapath register sources (PC, DR, R1–R5), arbitrates among them and issues one registered 3-bit write-select code per cycle to the write-enable decoder. It is the encoding end of the register write-select path: the decoder turns `sel_code` back into one-hot register enables. Requests are held sticky until granted, with an optional round-robin policy and collision reporting.

## Interface
- `IDLE_CODE`, default 3'd7: code driven when no write is issued; unmapped in the decoder, so no enable fires.
- `CNT_W`, default 8: width of the issued-write counter.

- `clk`  in  1  system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req`  in  7  write request strobes; bit0=PC, bit1=DR, bit2=R1 … bit6=R5.
- `hold`  in  1  controller stall; no grant is issued while high.
- `clr_err`  in  1  synchronous clear of `collision`.
- `sel_code`  out  3  selection code to the decoder: 0=PC, 1=DR, 2..6=R1..R5.
- `sel_valid`  out  1  `sel_code` carries a real write this cycle.
- `grant`  out  7  one-hot acknowledge of the source being written; all zero when idle.
- `pending`  out  7  latched, not-yet-granted requests.
- `collision`  out  1  sticky flag: a request arrived for a source already pending and not granted.
- `wr_count`  out  CNT_W  number of writes issued; saturates at all-ones.

## Operation
- Candidate set each cycle: `cand = pending | req`.
- FSM states:
  - IDLE: `cand` is 0 or `hold` is 1.
  - ISSUE: `cand` is nonzero and `hold` is 0.
- FSM transitions:
  - IDLE→ISSUE: `cand` becomes nonzero with `hold` low.
  - ISSUE→IDLE: `cand` becomes zero, or `hold` rises.
- ISSUE: select one index i from `cand`. On the clock edge:
  - `sel_code` ← i; `sel_valid` ← 1; `grant` ← one-hot(i); `wr_count` increments, saturating.
- IDLE: on the clock edge, `sel_code` ← IDLE_CODE, `sel_valid` ← 0, `grant` ← 0.
- Pending update per bit j:
  - Set if `req[j]` and j is not granted this cycle.
  - Cleared if j is granted and `pending[j]` was 0. A request for j arriving in its own grant cycle with `pending[j]`=0 is consumed by that grant.
  - If j is granted while `pending[j]`=1 and `req[j]`=1, the new request re-pends (bit stays 1). No collision is flagged.
- Collision: set when `req[j]`=1, `pending[j]`=1 and j is not granted this cycle. The duplicate is dropped.
- Collision versus `clr_err`: set has priority over `clr_err` in the same cycle.
- `hold` high: `req` still accumulates into `pending`. Collision detection remains active.
- Selection policy: fixed priority, lowest index wins (PC highest), unless the configuration below is compiled in.

## Timing
- Reset (async assert, sync release) values:
  - `sel_code` = IDLE_CODE; all other outputs, `sel_valid`, `grant`, `pending`, `collision` and `wr_count` = 0.
  - Round-robin pointer = 6, so the first search starts at index 0.
- Latency: a `req` sampled at edge k, with no competitor and `hold` low, gives `sel_valid`/`grant` high in the cycle after edge k. That is one cycle.
- All outputs are registered; there is no combinational path from inputs to outputs.
- Throughput: one write per cycle while `cand` is nonzero and `hold` is low.
- `hold` asserted at edge k: the cycle after k shows `sel_valid`=0. Issuing resumes the cycle after `hold` is sampled low.
- Reset mid-operation: `pending` is discarded and the outputs return to their reset values immediately.

## Configuration
- `WSE_ROUND_ROBIN_EN` defined:
  - A 3-bit pointer holds the last granted index.
  - The search starts at pointer+1 and wraps from 6 to 0.
  - The pointer updates only on a grant.
- `WSE_ROUND_ROBIN_EN` undefined: fixed priority, index 0 highest; the pointer logic is absent.

## Test plan
- Reset and idle:
  - Stimulus: assert `rst_n`=0 mid-burst, then release.
  - Required: `sel_code`=7, `sel_valid`=0, `pending`=0, `wr_count`=0; no grant until a new `req`.
- Single request:
  - Stimulus: `req`=7'b0000100 for one cycle.
  - Required: the next cycle shows `sel_code`=2, `grant`=7'b0000100, `wr_count`=1; the cycle after, `sel_valid`=0.
- Simultaneous requests:
  - Stimulus: `req`=7'h7F for one cycle.
  - Required, fixed priority: codes 0,1,2,3,4,5,6 on seven consecutive cycles.
  - Required, round-robin from reset: same order. Then a repeated `req`=7'b0000011 yields codes 0,1.
- Hold:
  - Stimulus: `hold`=1 while `req`=7'b1000001 pulses; release after 3 cycles.
  - Required: `pending`=7'b1000001 throughout the hold; then codes 0 then 6; `sel_valid` low during the hold.
- Collision:
  - Stimulus: with `hold`=1, pulse `req[3]` twice.
  - Required: `collision`=1, only one grant of code 3 after release; `clr_err` returns `collision` to 0.
- Regrant and saturation:
  - Stimulus: `req[1]` held high continuously with `pending[1]` set.
  - Required: code 1 issued every cycle, no collision. `wr_count` stops at 255.
